// File: rtl/adder_multi_op_seg_pkg.sv
// ============================================================================
// adder_pkg : segment codes, FSM encoding and elaboration helpers. Rev 1.0
// ============================================================================
`default_nettype none

package adder_pkg;

   // {dp,g,f,e,d,c,b,a}, active-high
   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_E     = 8'h79;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_CONVERT = 2'd1,
      ST_SHOW    = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   function automatic int pow10(input int n);
      int result = 1;
      for (int i = 0; i < n; i++) result = result * 10;
      return result;
   endfunction

endpackage

`default_nettype wire

// File: rtl/debounce.sv
// ============================================================================
// debounce : key synchroniser/debouncer, one-cycle pulse per settled press. Rev 1.0
// ============================================================================
`default_nettype none

module debounce #(
   parameter int DB_CYCLES = 500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic key_pulse
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic [1:0]    r_sync;
   logic          r_stable;
   logic [CW-1:0] r_cnt;
   logic          w_settled;

   assign w_settled = (r_cnt == CW'(DB_CYCLES - 1));

   // The key level must differ from the accepted level for DB_CYCLES
   // consecutive cycles; any bounce back restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync    <= '0;
         r_stable  <= 1'b0;
         r_cnt     <= '0;
         key_pulse <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], key};
         key_pulse <= 1'b0;
         if (r_sync[1] == r_stable) begin
            r_cnt <= '0;
         end else if (w_settled) begin
            r_stable  <= r_sync[1];
            r_cnt     <= '0;
            key_pulse <= r_sync[1];
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// seg7_decode : 4-bit BCD to 7-segment code, 0xE shows 'E'. Rev 1.0
// ============================================================================
`default_nettype none

module seg7_decode
   import adder_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [7:0] code
);

   always_comb begin
      code = SEG_BLANK;
      case (bcd)
         4'd0:    code = SEG_0;
         4'd1:    code = SEG_1;
         4'd2:    code = SEG_2;
         4'd3:    code = SEG_3;
         4'd4:    code = SEG_4;
         4'd5:    code = SEG_5;
         4'd6:    code = SEG_6;
         4'd7:    code = SEG_7;
         4'd8:    code = SEG_8;
         4'd9:    code = SEG_9;
         4'hE:    code = SEG_E;
         default: code = SEG_BLANK;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/adder_multi_op_seg.sv
// ============================================================================
// adder_multi_op_seg : keyed N-operand adder with double-dabble 7-seg display. Rev 1.0
// ============================================================================
`default_nettype none

module adder_multi_op_seg
   import adder_pkg::*;
#(
   parameter  int WIDTH           = 4,
   parameter  int N_OPS           = 2,
   parameter  int DIGITS          = 2,
   parameter  int DEBOUNCE_CYCLES = 500_000,
   localparam int SUM_W           = WIDTH + clog2(N_OPS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_cfm,
   input  logic [WIDTH-1:0]      add_num,
   output logic [SUM_W-1:0]      sum,
   output logic [9*DIGITS-1:0]   seg,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf
);

   localparam int REM_W   = clog2(N_OPS + 1);
   localparam int CNT_W   = clog2(SUM_W + 1);
   localparam int BCD_W   = 4 * DIGITS;
   localparam int CMP_W   = (SUM_W > 14) ? SUM_W : 14;
   localparam int MAX_DEC = pow10(DIGITS) - 1;

   state_t           r_state, w_state_next;
   logic [SUM_W-1:0] r_acc, w_acc_next, w_acc_sum;
   logic [REM_W-1:0] r_rem, w_rem_next;
   logic [SUM_W-1:0] r_bin, w_bin_next;
   logic [BCD_W-1:0] r_bcd, w_bcd_next, w_bcd_adj;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic [BCD_W-1:0] r_digit, w_digit_next;
   logic             r_ovf, w_ovf_next;
   logic             r_busy, r_done;
   logic             w_pulse, w_fits;

   debounce #(.DB_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .key       (key_cfm),
      .key_pulse (w_pulse)
   );

   assign w_acc_sum = r_acc + {{(SUM_W - WIDTH){1'b0}}, add_num};
   assign w_fits    = (CMP_W'(r_acc) <= CMP_W'(MAX_DEC));

   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_acc_next   = r_acc;
      w_rem_next   = r_rem;
      w_bin_next   = r_bin;
      w_bcd_next   = r_bcd;
      w_cnt_next   = r_cnt;
      w_ovf_next   = r_ovf;
      case (r_state)
         ST_COLLECT: begin
            if (w_pulse) begin
               w_acc_next = w_acc_sum;
               w_rem_next = r_rem - REM_W'(1);
               if (r_rem == REM_W'(1)) begin
                  w_bin_next   = w_acc_sum;
                  w_bcd_next   = '0;
                  w_cnt_next   = CNT_W'(SUM_W);
                  w_state_next = ST_CONVERT;
               end
            end
         end
         ST_CONVERT: begin
            // One idle cycle after the last shift lets the BCD settle before SHOW.
            if (r_cnt != '0) begin
               {w_bcd_next, w_bin_next} = {w_bcd_adj, r_bin} << 1;
               w_cnt_next = r_cnt - CNT_W'(1);
            end else begin
               w_ovf_next   = !w_fits;
               w_state_next = ST_SHOW;
            end
         end
         ST_SHOW: begin
            if (w_pulse) begin
               w_acc_next   = '0;
               w_rem_next   = REM_W'(N_OPS);
               w_ovf_next   = 1'b0;
               w_state_next = ST_COLLECT;
            end
         end
         default: w_state_next = ST_COLLECT;
      endcase
   end

   // Digit nibbles are computed from next-state values so seg is registered
   // alongside the state it reflects.
   always_comb begin
      w_digit_next = '0;
      case (w_state_next)
         ST_COLLECT: w_digit_next[3:0] = 4'(w_rem_next);
         ST_SHOW: begin
            for (int i = 0; i < DIGITS; i++) begin
               w_digit_next[4*i +: 4] = w_ovf_next ? 4'hE : w_bcd_next[4*i +: 4];
            end
         end
         default: w_digit_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_COLLECT;
         r_acc   <= '0;
         r_rem   <= REM_W'(N_OPS);
         r_bin   <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_digit <= BCD_W'(N_OPS);
      end else begin
         r_state <= w_state_next;
         r_acc   <= w_acc_next;
         r_rem   <= w_rem_next;
         r_bin   <= w_bin_next;
         r_bcd   <= w_bcd_next;
         r_cnt   <= w_cnt_next;
         r_ovf   <= w_ovf_next;
         r_busy  <= (w_state_next == ST_CONVERT);
         r_done  <= (w_state_next == ST_SHOW);
         r_digit <= w_digit_next;
      end
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      logic [7:0] code;
      seg7_decode u_dec (
         .bcd  (r_digit[4*i +: 4]),
         .code (code)
      );
      assign seg[9*i +: 9] = {1'b1, code};
   end

   assign sum  = ~r_acc;
   assign busy = r_busy;
   assign done = r_done;
   assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_adder_multi_op_seg.sv
// ============================================================================
// tb_adder_multi_op_seg : directed bench over four parameter sets. Rev 1.0
// ============================================================================
`default_nettype none

module tb_adder_multi_op_seg;

   localparam int DB = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  keys;
   logic [15:0] add_num;
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   // a: defaults, b: N_OPS=3, c: DIGITS=1, d: WIDTH=16/DIGITS=4 (long CONVERT)
   logic [4:0]  sum_a;  logic [17:0] seg_a;  logic busy_a, done_a, ovf_a;
   logic [5:0]  sum_b;  logic [17:0] seg_b;  logic busy_b, done_b, ovf_b;
   logic [4:0]  sum_c;  logic [8:0]  seg_c;  logic busy_c, done_c, ovf_c;
   logic [16:0] sum_d;  logic [35:0] seg_d;  logic busy_d, done_d, ovf_d;
   logic [3:0]  busy_x, done_x;

   assign busy_x = {busy_d, busy_c, busy_b, busy_a};
   assign done_x = {done_d, done_c, done_b, done_a};

   adder_multi_op_seg #(.WIDTH(4), .N_OPS(2), .DIGITS(2), .DEBOUNCE_CYCLES(DB)) u_dut_a (
      .clk(clk), .rst(rst), .key_cfm(keys[0]), .add_num(add_num[3:0]),
      .sum(sum_a), .seg(seg_a), .busy(busy_a), .done(done_a), .ovf(ovf_a));
   adder_multi_op_seg #(.WIDTH(4), .N_OPS(3), .DIGITS(2), .DEBOUNCE_CYCLES(DB)) u_dut_b (
      .clk(clk), .rst(rst), .key_cfm(keys[1]), .add_num(add_num[3:0]),
      .sum(sum_b), .seg(seg_b), .busy(busy_b), .done(done_b), .ovf(ovf_b));
   adder_multi_op_seg #(.WIDTH(4), .N_OPS(2), .DIGITS(1), .DEBOUNCE_CYCLES(DB)) u_dut_c (
      .clk(clk), .rst(rst), .key_cfm(keys[2]), .add_num(add_num[3:0]),
      .sum(sum_c), .seg(seg_c), .busy(busy_c), .done(done_c), .ovf(ovf_c));
   adder_multi_op_seg #(.WIDTH(16), .N_OPS(2), .DIGITS(4), .DEBOUNCE_CYCLES(DB)) u_dut_d (
      .clk(clk), .rst(rst), .key_cfm(keys[3]), .add_num(add_num),
      .sum(sum_d), .seg(seg_d), .busy(busy_d), .done(done_d), .ovf(ovf_d));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic enter(input int d, input logic [15:0] v);
      add_num = v;
      keys[d] = 1'b1;
      repeat (DB + 6) tick();
      keys[d] = 1'b0;
      repeat (DB + 6) tick();
   endtask

   // Leaves the key held; returns on the first cycle busy is seen.
   task automatic press_final(input int d, input logic [15:0] v);
      int n = 0;
      add_num = v;
      keys[d] = 1'b1;
      while (!busy_x[d] && n < 40) begin
         tick();
         n++;
      end
      check("busy_rise", 64'(busy_x[d]), 64'd1);
   endtask

   task automatic wait_done(input int d);
      int n = 0;
      while (!done_x[d] && n < 200) begin
         tick();
         n++;
      end
      check("done_rise", 64'(done_x[d]), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; keys = '0; add_num = '0;
      repeat (3) tick();
      rst = 1'b1;
      tick();

      check("a_rst_sum",   64'(sum_a), 64'h1F);
      check("a_rst_seg",   64'(seg_a), 64'({9'h13F, 9'h15B}));
      check("a_rst_flags", 64'({busy_a, done_a, ovf_a}), 64'd0);
      check("b_rst_sum",   64'(sum_b), 64'h3F);
      check("b_rst_seg",   64'(seg_b), 64'({9'h13F, 9'h14F}));
      check("c_rst_seg",   64'(seg_c), 64'h15B);
      check("d_rst_seg",   64'(seg_d), 64'({9'h13F, 9'h13F, 9'h13F, 9'h15B}));

      // 7 + 9 on defaults, with exact conversion latency
      enter(0, 16'd7);
      check("a_op1_seg", 64'(seg_a), 64'({9'h13F, 9'h106}));
      check("a_op1_sum", 64'(sum_a), 64'h18);
      press_final(0, 16'd9);
      check("a_conv_seg", 64'(seg_a), 64'({9'h13F, 9'h13F}));
      check("a_conv_sum", 64'(sum_a), 64'h0F);
      repeat (5) tick();
      check("a_pre_done", 64'({busy_a, done_a}), 64'b10);
      tick();
      check("a_done_flags", 64'({busy_a, done_a, ovf_a}), 64'b010);
      check("a_res_seg",    64'(seg_a), 64'({9'h106, 9'h17D}));
      check("a_res_sum",    64'(sum_a), 64'h0F);
      keys[0] = 1'b0;
      repeat (DB + 6) tick();
      check("a_show_hold", 64'({busy_a, done_a}), 64'b01);

      // restart pulse must not sample add_num
      enter(0, 16'hA);
      check("a_restart_seg",  64'(seg_a), 64'({9'h13F, 9'h15B}));
      check("a_restart_sum",  64'(sum_a), 64'h1F);
      check("a_restart_done", 64'(done_a), 64'd0);

      // 15 + 15
      enter(0, 16'd15);
      check("a2_op1_seg", 64'(seg_a), 64'({9'h13F, 9'h106}));
      check("a2_op1_sum", 64'(sum_a), 64'h10);
      press_final(0, 16'd15);
      check("a2_conv_seg", 64'(seg_a), 64'({9'h13F, 9'h13F}));
      keys[0] = 1'b0;
      wait_done(0);
      check("a2_res_seg", 64'(seg_a), 64'({9'h14F, 9'h13F}));
      check("a2_res_sum", 64'(sum_a), 64'h01);
      check("a2_res_ovf", 64'(ovf_a), 64'd0);

      // N_OPS=3: 15 + 15 + 15, then restart
      enter(1, 16'd15);
      check("b_op1_seg", 64'(seg_b), 64'({9'h13F, 9'h15B}));
      enter(1, 16'd15);
      check("b_op2_seg", 64'(seg_b), 64'({9'h13F, 9'h106}));
      press_final(1, 16'd15);
      keys[1] = 1'b0;
      wait_done(1);
      check("b_res_seg", 64'(seg_b), 64'({9'h166, 9'h16D}));
      check("b_res_sum", 64'(sum_b), 64'h12);
      check("b_res_ovf", 64'(ovf_b), 64'd0);
      enter(1, 16'd15);
      check("b_restart_seg",  64'(seg_b), 64'({9'h13F, 9'h14F}));
      check("b_restart_sum",  64'(sum_b), 64'h3F);
      check("b_restart_done", 64'(done_b), 64'd0);

      // five bounce edges shorter than the debounce window, then settle
      add_num = 16'd6;
      keys[1] = 1'b1; tick();
      keys[1] = 1'b0; tick();
      keys[1] = 1'b1; tick();
      keys[1] = 1'b0; tick();
      keys[1] = 1'b1;
      repeat (DB + 6) tick();
      keys[1] = 1'b0;
      repeat (DB + 6) tick();
      check("b_bounce_seg", 64'(seg_b), 64'({9'h13F, 9'h15B}));
      check("b_bounce_sum", 64'(sum_b), 64'h39);

      // DIGITS=1: 5 + 7 overflows
      enter(2, 16'd5);
      check("c_op1_seg", 64'(seg_c), 64'h106);
      press_final(2, 16'd7);
      keys[2] = 1'b0;
      wait_done(2);
      check("c_res_seg", 64'(seg_c), 64'h179);
      check("c_res_ovf", 64'(ovf_c), 64'd1);
      check("c_res_sum", 64'(sum_c), 64'h13);

      // extra confirm during CONVERT is ignored
      enter(3, 16'd1234);
      check("d_op1_seg", 64'(seg_d), 64'({9'h13F, 9'h13F, 9'h13F, 9'h106}));
      press_final(3, 16'd4321);
      keys[3] = 1'b0;
      add_num = 16'd9;
      repeat (6) tick();
      keys[3] = 1'b1;
      repeat (8) tick();
      check("d_busy_after_extra", 64'(busy_d), 64'd1);
      keys[3] = 1'b0;
      wait_done(3);
      check("d_res_seg", 64'(seg_d), 64'({9'h16D, 9'h16D, 9'h16D, 9'h16D}));
      check("d_res_sum", 64'(sum_d), 64'h1EA4C);
      check("d_res_ovf", 64'(ovf_d), 64'd0);

      // asynchronous reset in the middle of CONVERT
      enter(3, 16'd0);
      enter(3, 16'd1);
      press_final(3, 16'd2);
      keys[3] = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      check("d_midrst_sum",   64'(sum_d), 64'h1FFFF);
      check("d_midrst_seg",   64'(seg_d), 64'({9'h13F, 9'h13F, 9'h13F, 9'h15B}));
      check("d_midrst_flags", 64'({busy_d, done_d, ovf_d}), 64'd0);
      tick();
      rst = 1'b1;
      tick();

      // 9999 + 1 exceeds four digits
      enter(3, 16'd9999);
      press_final(3, 16'd1);
      keys[3] = 1'b0;
      wait_done(3);
      check("d2_res_seg", 64'(seg_d), 64'({9'h179, 9'h179, 9'h179, 9'h179}));
      check("d2_res_ovf", 64'(ovf_d), 64'd1);
      check("d2_res_sum", 64'(sum_d), 64'h1D8EF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
